// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared encodings, pattern tables and LFSR helper for the PHY traffic gen/checker
//
// Purpose: mode and FSM encodings, the fixed per-lane pattern table, LFSR
// polynomial/seed and a single-step LFSR helper shared by the tx and checker
// pattern generators.
package phy_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_IDLE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Per-lane constant words; only the low WIDTH bits are emitted.
    localparam logic [15:0] PAT_FIXED [8] = '{
        16'h0000, 16'h00EE, 16'h00FF, 16'h00FD,
        16'h00A5, 16'h005A, 16'h00C3, 16'h003C
    };

    // Galois right-shift step: feedback taps applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/phy_pattern_lane.sv
// rtl/phy_pattern_lane.sv - one lane of the FIXED/INCR/LFSR word generator
//
// Purpose: produces the current pattern word for one lane; steps to the next
// word on advance_i. restart_i reseeds, and while it is high the word output
// already shows the seed word so the owner can emit word 0 in the same cycle.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   mode_i         pattern mode
//   restart_i      reseed (takes effect combinationally on word_o)
//   advance_i      step to the next word after this one
//   word_o         current WIDTH-bit word
module phy_pattern_lane
    import phy_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LANE_IDX = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  mode_e            mode_i,
    input  logic             restart_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] word_o
);

    localparam int          SHIFT     = (WIDTH >= 2) ? WIDTH - 2 : 0;
    localparam logic [15:0] INCR_BASE = (WIDTH >= 2) ? 16'(LANE_IDX << SHIFT) : 16'h0000;
    localparam logic [15:0] LFSR_INIT = LFSR_SEED ^ 16'(LANE_IDX + 1);

    // state_q is the word counter k in INCR mode and the LFSR register in LFSR mode.
    logic [15:0] state_q, state_d;
    logic [15:0] cur;
    logic [15:0] word16;

    always_comb begin
        cur = state_q;
        if (restart_i) begin
            cur = (mode_i == MODE_LFSR) ? LFSR_INIT : 16'h0000;
        end
        state_d = cur;
        if (advance_i) begin
            state_d = (mode_i == MODE_LFSR) ? lfsr_step(cur) : cur + 16'd1;
        end
        case (mode_i)
            MODE_FIXED: word16 = PAT_FIXED[LANE_IDX];
            MODE_INCR:  word16 = INCR_BASE + cur;
            MODE_LFSR:  word16 = cur;
            default:    word16 = 16'h0000;
        endcase
    end

    assign word_o = word16[WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= 16'h0000;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/phy_traffic_gen_chk.sv
// rtl/phy_traffic_gen_chk.sv - PHY lane traffic generator and loopback checker
//
// Purpose: drives LANES x WIDTH pattern words into the transmitter and checks
// the receiver stream against a per-lane regenerated expectation.
// Ports:
//   clk_f, reset          clock, asynchronous active-low reset
//   start                 begin a run (honoured in IDLE/DONE only)
//   mode, burst_len,      run configuration, latched at start
//   gap_every
//   data_out, valid_out   transmit words, lane i at [i*WIDTH +: WIDTH]
//   data_in, valid_in     received words, same packing
//   busy, done, timeout   run status
//   err_count, rx_count   saturating mismatch count (all lanes), lane-0 receive count
module phy_traffic_gen_chk
    import phy_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_f,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [15:0]            burst_len,
    input  logic [3:0]             gap_every,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [LANES-1:0]       valid_in,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [15:0]            err_count,
    output logic [15:0]            rx_count
);

    localparam int            IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    state_e                         state_q, state_d;
    mode_e                          mode_q, mode_d, run_mode;
    logic [15:0]                    burst_q, burst_d;
    logic [3:0]                     gap_q, gap_d;
    logic [3:0]                     gcnt_q, gcnt_d, gcn;
    logic [15:0]                    words_q, words_d;
    logic [IW-1:0]                  idle_q, idle_d;
    logic [LANES*WIDTH-1:0]         dout_q, dout_d;
    logic [LANES-1:0]               vout_q, vout_d;
    logic                           tmo_q, tmo_d;
    logic [15:0]                    err_q, err_d;
    logic [15:0]                    rx_q, rx_d;
    logic [LANES-1:0][15:0]         rcnt_q, rcnt_d;

    logic                           restart, tx_adv, gap_hit, all_rx_done, busy_w;
    logic [LANES-1:0]               chk_adv, in_range, bad;
    logic [16:0]                    err_acc;
    logic [LANES-1:0][WIDTH-1:0]    tx_word, chk_word;

    assign busy_w = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        phy_pattern_lane #(.WIDTH(WIDTH), .LANE_IDX(g)) u_tx (
            .clk_i     (clk_f),
            .rst_ni    (reset),
            .mode_i    (run_mode),
            .restart_i (restart),
            .advance_i (tx_adv),
            .word_o    (tx_word[g])
        );
        phy_pattern_lane #(.WIDTH(WIDTH), .LANE_IDX(g)) u_chk (
            .clk_i     (clk_f),
            .rst_ni    (reset),
            .mode_i    (run_mode),
            .restart_i (restart),
            .advance_i (chk_adv[g]),
            .word_o    (chk_word[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        burst_d     = burst_q;
        gap_d       = gap_q;
        gcnt_d      = gcnt_q;
        words_d     = words_q;
        idle_d      = idle_q;
        dout_d      = dout_q;
        vout_d      = vout_q;
        tmo_d       = tmo_q;
        rx_d        = rx_q;
        rcnt_d      = rcnt_q;
        restart     = 1'b0;
        tx_adv      = 1'b0;
        run_mode    = mode_q;
        chk_adv     = '0;
        in_range    = '0;
        bad         = '0;
        all_rx_done = 1'b1;
        err_acc     = {1'b0, err_q};

        // Checker: words outside a run, or beyond burst_len on a lane, are errors
        // and do not advance that lane's expected stream.
        for (int i = 0; i < LANES; i++) begin
            in_range[i] = busy_w && (rcnt_q[i] < burst_q);
            chk_adv[i]  = valid_in[i] && in_range[i];
            bad[i]      = valid_in[i] &&
                          (!in_range[i] || (data_in[i*WIDTH +: WIDTH] != chk_word[i]));
            if (chk_adv[i]) begin
                rcnt_d[i] = rcnt_q[i] + 16'd1;
            end
            if (bad[i]) begin
                err_acc = err_acc + 17'd1;
            end
            if (rcnt_q[i] != burst_q) begin
                all_rx_done = 1'b0;
            end
        end
        err_d = err_acc[16] ? 16'hFFFF : err_acc[15:0];
        if (busy_w && valid_in[0] && (rx_q != 16'hFFFF)) begin
            rx_d = rx_q + 16'd1;
        end

        // Gap counter tracks c mod gap_every in the range 1..gap_every.
        gcn     = (gcnt_q >= gap_q) ? 4'd1 : gcnt_q + 4'd1;
        gap_hit = (gap_q != 4'd0) && (gcn == gap_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    restart  = 1'b1;
                    run_mode = mode_e'(mode);
                    mode_d   = mode_e'(mode);
                    burst_d  = burst_len;
                    gap_d    = gap_every;
                    gcnt_d   = 4'd1;
                    words_d  = 16'd0;
                    idle_d   = '0;
                    tmo_d    = 1'b0;
                    err_d    = 16'h0000;
                    rx_d     = 16'h0000;
                    rcnt_d   = '0;
                    if ((burst_len != 16'd0) && (mode_e'(mode) != MODE_IDLE)) begin
                        state_d = ST_RUN;
                        // Cycle c=1 is a gap only when gap_every is 1.
                        if (gap_every != 4'd1) begin
                            vout_d  = '1;
                            dout_d  = tx_word;
                            tx_adv  = 1'b1;
                            words_d = 16'd1;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                gcnt_d = gcn;
                if (words_q == burst_q) begin
                    state_d = ST_DRAIN;
                    vout_d  = '0;
                    dout_d  = '0;
                    idle_d  = '0;
                end else if (gap_hit) begin
                    vout_d = '0;
                end else begin
                    vout_d  = '1;
                    dout_d  = tx_word;
                    tx_adv  = 1'b1;
                    words_d = words_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (all_rx_done) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b0;
                end else if (valid_in == '0) begin
                    idle_d = idle_q + IDLE_ONE;
                    if (idle_q == IDLE_LAST) begin
                        state_d = ST_DONE;
                        tmo_d   = 1'b1;
                    end
                end else begin
                    idle_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FIXED;
            burst_q <= 16'h0000;
            gap_q   <= 4'd0;
            gcnt_q  <= 4'd0;
            words_q <= 16'h0000;
            idle_q  <= '0;
            dout_q  <= '0;
            vout_q  <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 16'h0000;
            rx_q    <= 16'h0000;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            words_q <= words_d;
            idle_q  <= idle_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            rx_q    <= rx_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign data_out  = dout_q;
    assign valid_out = vout_q;
    assign busy      = busy_w;
    assign done      = (state_q == ST_DONE);
    assign timeout   = tmo_q;
    assign err_count = err_q;
    assign rx_count  = rx_q;

endmodule

// File: tb/tb_phy_traffic_gen_chk.sv
// tb/tb_phy_traffic_gen_chk.sv - self-checking bench for phy_traffic_gen_chk
module tb_phy_traffic_gen_chk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  v;
    } beat_t;

    logic        clk_f;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic [3:0]  gap_every;
    logic [31:0] data_out, data_in;
    logic [3:0]  valid_out, valid_in;
    logic        busy, done, timeout;
    logic [15:0] err_count, rx_count;

    int checks = 0;
    int fails  = 0;

    beat_t tl[$];
    int    tl_idx    = 0;
    bit    tl_active = 0;

    beat_t lb_q[$];
    bit    lb_en      = 0;
    int    lb_delay   = 0;
    logic [3:0] stray_v = '0;
    bit    cor_en     = 0;
    int    cor_cnt    = 0;
    bit    model_busy = 0;
    int    m_mode     = 0;
    int    m_burst    = 0;
    int    mk[4];
    int    exp_err    = 0;
    int    exp_rx     = 0;

    phy_traffic_gen_chk #(.LANES(4), .WIDTH(8), .TIMEOUT(64)) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .burst_len (burst_len),
        .gap_every (gap_every),
        .data_out  (data_out),
        .valid_out (valid_out),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .err_count (err_count),
        .rx_count  (rx_count)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word k of lane `lane`, computed straight from the pattern definitions.
    function automatic logic [7:0] exp_word(input int m, input int lane, input int k);
        logic [15:0] s;
        case (m)
            0: case (lane)
                   0: return 8'h00;
                   1: return 8'hEE;
                   2: return 8'hFF;
                   default: return 8'hFD;
               endcase
            1: return 8'((lane * 64 + k) % 256);
            2: begin
                s = 16'hACE1 ^ 16'(lane + 1);
                for (int j = 0; j < k; j++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
                return s[7:0];
            end
            default: return 8'h00;
        endcase
    endfunction

    // Expected transmit timeline: one entry per RUN cycle plus the first DRAIN cycle.
    function automatic void build_tl(input int m, input int bl, input int g);
        int          words = 0;
        int          n     = 1;
        logic [31:0] last  = '0;
        beat_t       b;
        tl.delete();
        while (words < bl) begin
            if (g != 0 && (n % g) == 0) begin
                b.d = last;
                b.v = 4'h0;
            end else begin
                for (int l = 0; l < 4; l++) last[l*8 +: 8] = exp_word(m, l, words);
                b.d = last;
                b.v = 4'hF;
                words++;
            end
            tl.push_back(b);
            n++;
        end
        b.d = '0;
        b.v = 4'h0;
        tl.push_back(b);
    endfunction

    // Loopback / stray driver plus receive-side model.
    initial begin
        beat_t e;
        logic [7:0] w;
        data_in  = '0;
        valid_in = '0;
        forever begin
            @(negedge clk_f);
            if (lb_en) begin
                e.d = data_out;
                e.v = valid_out;
                lb_q.push_back(e);
                if (lb_q.size() > lb_delay) begin
                    e = lb_q.pop_front();
                end else begin
                    e.d = '0;
                    e.v = '0;
                end
                if (e.v[2]) begin
                    cor_cnt++;
                    if (cor_en && cor_cnt == 5) e.d[16] = ~e.d[16];
                end
            end else begin
                e.d = '0;
                e.v = stray_v;
            end
            data_in  = e.d;
            valid_in = e.v;
            for (int i = 0; i < 4; i++) begin
                if (e.v[i]) begin
                    w = e.d[i*8 +: 8];
                    if (!model_busy || mk[i] >= m_burst) begin
                        exp_err++;
                    end else begin
                        if (w != exp_word(m_mode, i, mk[i])) exp_err++;
                        mk[i]++;
                    end
                    if (i == 0 && model_busy) exp_rx++;
                end
            end
        end
    end

    // Per-cycle transmit comparison against the model timeline.
    initial begin
        forever begin
            @(negedge clk_f);
            if (tl_active) begin
                chk("tx_valid", valid_out, tl[tl_idx].v);
                chk("tx_data", data_out, tl[tl_idx].d);
                chk("tx_busy", busy, 1);
                tl_idx++;
                if (tl_idx >= tl.size()) tl_active = 0;
            end
        end
    end

    task automatic run_start(input int m, input int bl, input int g, input int dly);
        @(posedge clk_f);
        #1;
        mode      = 2'(m);
        burst_len = 16'(bl);
        gap_every = 4'(g);
        start     = 1'b1;
        lb_delay  = dly;
        m_mode    = m;
        m_burst   = bl;
        for (int i = 0; i < 4; i++) mk[i] = 0;
        exp_err    = 0;
        exp_rx     = 0;
        cor_cnt    = 0;
        model_busy = (bl != 0) && (m != 3);
        build_tl(m, bl, g);
        @(posedge clk_f);
        #1;
        start = 1'b0;
        lb_q.delete();
        tl_idx    = 0;
        tl_active = model_busy;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk_f);
            n++;
        end
        chk("done_reached", done, 1);
        model_busy = 0;
        @(negedge clk_f);
    endtask

    task automatic end_checks(input string tag, input int rx_lit, input int err_lit);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_err_lit"}, err_count, 32'(err_lit));
        chk({tag, "_rx_lit"}, rx_count, 32'(rx_lit));
        chk({tag, "_err_model"}, err_count, 32'(exp_err));
        chk({tag, "_rx_model"}, rx_count, 32'(exp_rx));
        chk({tag, "_idle_valid"}, valid_out, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        mode      = 2'd0;
        burst_len = 16'd0;
        gap_every = 4'd0;
        repeat (3) @(negedge clk_f);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err", err_count, 0);
        chk("rst_rx", rx_count, 0);
        reset = 1'b1;

        // Model pins against hand-computed words.
        chk("pin_incr_l3_k0", exp_word(1, 3, 0), 8'hC0);
        chk("pin_incr_l0_k255", exp_word(1, 0, 255), 8'hFF);
        chk("pin_incr_l0_k256", exp_word(1, 0, 256), 8'h00);
        chk("pin_lfsr_l0_k0", exp_word(2, 0, 0), 8'hE0);
        chk("pin_lfsr_l0_k1", exp_word(2, 0, 1), 8'h70);

        // 1: FIXED loopback
        lb_en = 1;
        run_start(0, 3, 0, 0);
        @(negedge clk_f);
        chk("t1_word0", data_out, 32'hFDFFEE00);
        chk("t1_valid0", valid_out, 4'hF);
        wait_done(50);
        end_checks("t1", 3, 0);

        // 2: INCR with gaps, 2-cycle delayed loopback
        run_start(1, 300, 3, 2);
        @(negedge clk_f);
        chk("t2_word0", data_out, 32'hC0804000);
        @(negedge clk_f);
        chk("t2_word1", data_out, 32'hC1814101);
        @(negedge clk_f);
        chk("t2_gap_valid", valid_out, 4'h0);
        chk("t2_gap_hold", data_out, 32'hC1814101);
        wait_done(1200);
        end_checks("t2", 300, 0);

        // 3: LFSR, lane 2 bit 0 corrupted on its 5th word
        cor_en = 1;
        run_start(2, 8, 0, 0);
        @(negedge clk_f);
        chk("t3_lane0_word0", data_out[7:0], 8'hE0);
        wait_done(100);
        cor_en = 0;
        end_checks("t3", 8, 1);

        // 4: no loopback -> timeout
        lb_en   = 0;
        stray_v = '0;
        run_start(0, 4, 0, 0);
        repeat (67) @(posedge clk_f);
        @(negedge clk_f);
        chk("t4_not_done_c68", done, 0);
        @(negedge clk_f);
        chk("t4_done_c69", done, 1);
        chk("t4_timeout", timeout, 1);
        chk("t4_rx", rx_count, 0);
        chk("t4_err", err_count, 0);
        model_busy = 0;

        // 5: reset mid-RUN, then a clean run
        lb_en = 1;
        run_start(0, 5, 0, 0);
        @(posedge clk_f);
        #2;
        tl_active = 0;
        reset     = 1'b0;
        #1;
        chk("t5_rst_valid", valid_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_data", data_out, 0);
        @(negedge clk_f);
        @(negedge clk_f);
        reset      = 1'b1;
        model_busy = 0;
        run_start(0, 3, 0, 0);
        wait_done(50);
        end_checks("t5", 3, 0);

        // 6: zero-length and IDLE-mode runs, then stray receive words in DONE
        run_start(0, 0, 0, 0);
        @(negedge clk_f);
        chk("t6a_done", done, 1);
        chk("t6a_valid", valid_out, 0);
        chk("t6a_busy", busy, 0);
        run_start(3, 5, 0, 0);
        @(negedge clk_f);
        chk("t6b_done", done, 1);
        chk("t6b_valid", valid_out, 0);
        @(negedge clk_f);
        chk("t6b_valid2", valid_out, 0);
        lb_en = 0;
        @(posedge clk_f);
        #1;
        stray_v = 4'b0001;
        @(posedge clk_f);
        #1;
        stray_v = 4'b0000;
        @(negedge clk_f);
        chk("t6_stray1_lit", err_count, 1);
        chk("t6_stray1_model", err_count, 32'(exp_err));
        @(posedge clk_f);
        #1;
        stray_v = 4'b0110;
        @(posedge clk_f);
        #1;
        stray_v = 4'b0000;
        @(negedge clk_f);
        chk("t6_stray2_lit", err_count, 3);
        chk("t6_stray2_model", err_count, 32'(exp_err));
        chk("t6_done_hold", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
